// File: rtl/lift_pkg.sv
// Shared definitions for the lift core controller: FSM encoding, job sizes and
// the core's result read latency.
package lift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDREQ  = 3'd4,
    ST_RDWAIT = 3'd5,
    ST_HOLD   = 3'd6
  } lift_state_e;

  localparam int unsigned DATA_W      = 240;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned BEATS_SMALL = 6;
  localparam int unsigned BEATS_BIG   = 12;
  // Cycles from core_rd_en to core_dout being valid.
  localparam int unsigned RD_LAT      = 1;

  // Address of the final operand write for a given lift mode.
  function automatic logic [ADDR_W-1:0] last_beat(input logic mode);
    return mode ? ADDR_W'(BEATS_BIG - 1) : ADDR_W'(BEATS_SMALL - 1);
  endfunction

endpackage

// File: rtl/lift_wdog.sv
// Watchdog for the wait-for-core phase: counts enabled cycles from a clear and
// flags expiry on the cycle the count reaches LIMIT-1. Saturates, never wraps.
module lift_wdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Clear has priority; counting stops at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CW'(LIMIT - 1))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = enable_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lift_core_ctrl.sv
// Host-to-core sequencer for the lift accelerator: streams operand beats into
// the core buffer, kicks the core, waits (with watchdog) for results, then
// reads them back one word at a time under host backpressure.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ready for the first beat of a job
//   ST_LOAD   | accepting remaining operand beats, one write per beat
//   ST_KICK   | operands written; core_start issued next cycle
//   ST_WAIT   | waiting for core_res_done, watchdog running
//   ST_RDREQ  | core_rd_en visible for the current result index
//   ST_RDWAIT | waiting out the core read latency, then capture
//   ST_HOLD   | result presented to host until out_ready
module lift_core_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned RES_WORDS = 6,
  parameter int unsigned WD_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_mode,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_din,
  output logic              core_we,
  output logic              core_we_done,
  output logic              core_rd_en,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_res_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              job_done,
  output logic              wd_err
);

  localparam int unsigned RIDX_W = 3;
  localparam int unsigned LAT_W  = 2;
  localparam logic [RIDX_W-1:0] LAST_RES = RIDX_W'(RES_WORDS - 1);

  lift_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  beat_q, beat_d;
  logic [RIDX_W-1:0]  res_idx_q, res_idx_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               mode_q, mode_d;
  logic               wd_err_q, wd_err_d;
  logic               job_done_q, job_done_d;
  logic               core_start_q, core_start_d;
  logic               core_we_q, core_we_d;
  logic               core_we_done_q, core_we_done_d;
  logic               core_rd_en_q, core_rd_en_d;
  logic [ADDR_W-1:0]  core_addr_q, core_addr_d;
  logic [DATA_W-1:0]  core_din_q, core_din_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               wd_expire;

  lift_wdog #(
    .LIMIT (WD_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != ST_WAIT),
    .enable_i (state_q == ST_WAIT),
    .expire_o (wd_expire)
  );

  // All state and every output register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      beat_q         <= '0;
      res_idx_q      <= '0;
      lat_q          <= '0;
      mode_q         <= 1'b0;
      wd_err_q       <= 1'b0;
      job_done_q     <= 1'b0;
      core_start_q   <= 1'b0;
      core_we_q      <= 1'b0;
      core_we_done_q <= 1'b0;
      core_rd_en_q   <= 1'b0;
      core_addr_q    <= '0;
      core_din_q     <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      res_idx_q      <= res_idx_d;
      lat_q          <= lat_d;
      mode_q         <= mode_d;
      wd_err_q       <= wd_err_d;
      job_done_q     <= job_done_d;
      core_start_q   <= core_start_d;
      core_we_q      <= core_we_d;
      core_we_done_q <= core_we_done_d;
      core_rd_en_q   <= core_rd_en_d;
      core_addr_q    <= core_addr_d;
      core_din_q     <= core_din_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
    end
  end

  // Next state plus the values the output registers take next cycle. Core
  // strobes are decided one cycle ahead so no host input reaches core_* ports
  // without passing through a flop.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    res_idx_d      = res_idx_q;
    lat_d          = lat_q;
    mode_d         = mode_q;
    wd_err_d       = wd_err_q;
    job_done_d     = 1'b0;
    core_start_d   = 1'b0;
    core_we_d      = 1'b0;
    core_we_done_d = 1'b0;
    core_rd_en_d   = 1'b0;
    core_addr_d    = core_addr_q;
    core_din_d     = core_din_q;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d      = cfg_mode;
          wd_err_d    = 1'b0;
          core_we_d   = 1'b1;
          core_addr_d = '0;
          core_din_d  = in_data;
          beat_d      = ADDR_W'(1);
          if (last_beat(cfg_mode) == '0) begin
            core_we_done_d = 1'b1;
            state_d        = ST_KICK;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          core_we_d   = 1'b1;
          core_addr_d = beat_q;
          core_din_d  = in_data;
          if (beat_q == last_beat(mode_q)) begin
            core_we_done_d = 1'b1;
            state_d        = ST_KICK;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      ST_KICK: begin
        core_start_d = 1'b1;
        state_d      = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_res_done) begin
          res_idx_d    = '0;
          core_rd_en_d = 1'b1;
          core_addr_d  = '0;
          state_d      = ST_RDREQ;
        end else if (wd_expire) begin
          wd_err_d   = 1'b1;
          job_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_RDREQ: begin
        lat_d   = '0;
        state_d = ST_RDWAIT;
      end

      ST_RDWAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          out_data_d  = core_dout;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      ST_HOLD: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (res_idx_q == LAST_RES) begin
            job_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            res_idx_d    = res_idx_q + 1'b1;
            core_rd_en_d = 1'b1;
            core_addr_d  = {1'b0, res_idx_q + 3'd1};
            state_d      = ST_RDREQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready     = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy         = (state_q != ST_IDLE);
  assign core_mode    = mode_q;
  assign core_start   = core_start_q;
  assign core_we      = core_we_q;
  assign core_we_done = core_we_done_q;
  assign core_rd_en   = core_rd_en_q;
  assign core_addr    = core_addr_q;
  assign core_din     = core_din_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign job_done     = job_done_q;
  assign wd_err       = wd_err_q;

endmodule

// File: tb/tb_lift_core_ctrl.sv
// Randomized bench for lift_core_ctrl with a job-level reference model and a
// small core model that returns per-job result words one cycle after a read.
module tb_lift_core_ctrl;

  localparam int RES = 6;
  localparam int WD  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_mode;
  logic         in_valid;
  logic         in_ready;
  logic [239:0] in_data;
  logic         core_mode;
  logic         core_start;
  logic [3:0]   core_addr;
  logic [239:0] core_din;
  logic         core_we;
  logic         core_we_done;
  logic         core_rd_en;
  logic [239:0] core_dout;
  logic         core_res_done;
  logic         out_valid;
  logic         out_ready;
  logic [239:0] out_data;
  logic         busy;
  logic         job_done;
  logic         wd_err;

  lift_core_ctrl #(
    .RES_WORDS (RES),
    .WD_CYCLES (WD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .core_mode     (core_mode),
    .core_start    (core_start),
    .core_addr     (core_addr),
    .core_din      (core_din),
    .core_we       (core_we),
    .core_we_done  (core_we_done),
    .core_rd_en    (core_rd_en),
    .core_dout     (core_dout),
    .core_res_done (core_res_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .job_done      (job_done),
    .wd_err        (wd_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired waiting for the DUT at t=%0t", name, $time);
  endtask

  function automatic logic [239:0] rand_word();
    logic [239:0] w;
    for (int i = 0; i < 8; i++) w[i*30 +: 30] = 30'($urandom);
    return w;
  endfunction

  // ---------------- core model ----------------
  logic [239:0] res_mem [8];
  logic         drv_rd;
  logic [3:0]   drv_addr;

  always @(negedge clk) begin
    drv_rd   = core_rd_en;
    drv_addr = core_addr;
  end

  always @(posedge clk) begin
    #1;
    core_dout = (drv_rd === 1'b1) ? res_mem[drv_addr[2:0]] : rand_word();
  end

  // ---------------- event counters for literal pins ----------------
  int         cyc = 0, cnt_we = 0, cnt_start = 0, cnt_rd = 0, cnt_jd = 0;
  int         wedone_cyc = 0, start_cyc = 0, jd_cyc = 0;
  logic [3:0] wedone_addr = '0, max_we_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (core_we === 1'b1) begin
      cnt_we++;
      if (core_addr > max_we_addr) max_we_addr = core_addr;
    end
    if (core_we_done === 1'b1) begin
      wedone_cyc  = cyc;
      wedone_addr = core_addr;
    end
    if (core_start === 1'b1) begin
      cnt_start++;
      start_cyc = cyc;
    end
    if (core_rd_en === 1'b1) cnt_rd++;
    if (job_done === 1'b1) begin
      cnt_jd++;
      jd_cyc = cyc;
    end
  end

  // ---------------- reference model ----------------
  // Job phases: idle, taking beats, last write in flight, core running,
  // results streaming out.
  localparam int P_IDLE = 0, P_LOAD = 1, P_TAIL = 2, P_WAIT = 3, P_READ = 4;

  bit           armed = 0;
  int           ph, m_n, m_acc, pw_idx, wait_k, lat, rd_idx;
  bit           m_mode, pw_v, m_wd_err, jd_next, rd_due, ov;
  logic [239:0] pw_data, ov_data;

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 240'(in_ready), 240'(ph == P_IDLE || ph == P_LOAD));
      chk("busy", 240'(busy), 240'(ph != P_IDLE));
      chk("core_we", 240'(core_we), 240'(pw_v));
      chk("core_we_done", 240'(core_we_done), 240'(pw_v && pw_idx == m_n - 1));
      if (pw_v) begin
        chk("write_addr", 240'(core_addr), 240'(pw_idx));
        chk("write_data", core_din, pw_data);
      end
      chk("core_start", 240'(core_start), 240'(ph == P_WAIT && wait_k == 0));
      chk("core_rd_en", 240'(core_rd_en), 240'(rd_due));
      if (rd_due) chk("read_addr", 240'(core_addr), 240'(rd_idx));
      chk("core_mode", 240'(core_mode), 240'(m_mode));
      chk("out_valid", 240'(out_valid), 240'(ov));
      if (ov) chk("out_data", out_data, ov_data);
      chk("job_done", 240'(job_done), 240'(jd_next));
      chk("wd_err", 240'(wd_err), 240'(m_wd_err));
    end

    if (rst === 1'b0) begin
      ph = P_IDLE; m_mode = 0; m_n = 6; m_acc = 0;
      pw_v = 0; pw_idx = 0; pw_data = '0; wait_k = 0;
      m_wd_err = 0; jd_next = 0; rd_due = 0; lat = 0;
      ov = 0; ov_data = '0; rd_idx = 0;
      armed = 1;
    end else if (armed) begin
      jd_next = 0;
      pw_v    = 0;
      case (ph)
        P_IDLE: if (in_valid) begin
          m_mode   = cfg_mode;
          m_n      = cfg_mode ? 12 : 6;
          m_wd_err = 0;
          pw_v = 1; pw_idx = 0; pw_data = in_data;
          m_acc = 1;
          ph = (m_acc == m_n) ? P_TAIL : P_LOAD;
        end
        P_LOAD: if (in_valid) begin
          pw_v = 1; pw_idx = m_acc; pw_data = in_data;
          m_acc++;
          if (m_acc == m_n) ph = P_TAIL;
        end
        P_TAIL: begin
          ph = P_WAIT;
          wait_k = 0;
        end
        P_WAIT: begin
          if (core_res_done) begin
            ph = P_READ; rd_idx = 0; rd_due = 1;
          end else if (wait_k == WD - 1) begin
            ph = P_IDLE; m_wd_err = 1; jd_next = 1;
          end else begin
            wait_k++;
          end
        end
        P_READ: begin
          if (rd_due) begin
            rd_due = 0;
            lat = 1;
          end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
              ov = 1;
              ov_data = res_mem[rd_idx];
            end
          end else if (ov && out_ready) begin
            ov = 0;
            if (rd_idx == RES - 1) begin
              ph = P_IDLE; jd_next = 1;
            end else begin
              rd_idx++; rd_due = 1;
            end
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  int b_we, b_rd, b_jd, b_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_we = cnt_we; b_rd = cnt_rd; b_jd = cnt_jd; b_start = cnt_start;
    max_we_addr = '0;
    for (int i = 0; i < 8; i++) res_mem[i] = rand_word();
  endtask

  task automatic run_load(input logic mode, input int gap_pct, input bit toggle,
                          input bit spurious, input int abort_after);
    int n, sent, guard;
    n = mode ? 12 : 6;
    sent = 0; guard = 0;
    cfg_mode = mode;
    while (sent < n && guard < 500) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = rand_word();
      if (toggle && sent > 0) cfg_mode = 1'($urandom_range(1));
      core_res_done = spurious && sent > 0 && ($urandom_range(3) == 0);
      if (in_valid && in_ready) sent++;
      tick();
      guard++;
      if (abort_after > 0 && sent == abort_after) break;
    end
    in_valid = 1'b0;
    core_res_done = 1'b0;
    if (guard >= 500) timeout_fail("load_beats");
  endtask

  task automatic wait_start();
    int g = 0;
    while (cnt_start == b_start && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) timeout_fail("core_start");
  endtask

  task automatic respond(input int delay);
    repeat (delay) tick();
    core_res_done = 1'b1;
    tick();
    core_res_done = 1'b0;
  endtask

  task automatic run_reads(input bit stall);
    int acc = 0, hold = 0, g = 0;
    while (cnt_jd == b_jd && g < 2000) begin
      if (stall && acc == 2 && hold < 10) begin
        out_ready = 1'b0;
        if (out_valid) hold++;
      end else begin
        out_ready = ($urandom_range(99) < 70);
      end
      if (out_valid && out_ready) acc++;
      tick();
      g++;
    end
    out_ready = 1'b0;
    if (g >= 2000) timeout_fail("job_done");
  endtask

  task automatic full_job(input logic mode, input int gap, input bit toggle,
                          input bit spurious, input bit stall);
    snap();
    run_load(mode, gap, toggle, spurious, 0);
    wait_start();
    respond($urandom_range(20));
    run_reads(stall);
    repeat ($urandom_range(3)) tick();
  endtask

  initial begin
    int g;
    rst = 1'b0; cfg_mode = 1'b0; in_valid = 1'b0; in_data = '0;
    core_res_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) res_mem[i] = rand_word();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("pin_reset_in_ready", 240'(in_ready), 240'(1));
    chk("pin_reset_busy", 240'(busy), 240'(0));

    // small job, continuous beats
    snap();
    run_load(1'b0, 0, 1'b0, 1'b0, 0);
    wait_start();
    respond(2);
    run_reads(1'b0);
    chk("pin_small_writes", 240'(cnt_we - b_we), 240'(6));
    chk("pin_small_lastaddr", 240'(wedone_addr), 240'(5));
    chk("pin_small_start_lag", 240'(start_cyc - wedone_cyc), 240'(1));
    chk("pin_small_reads", 240'(cnt_rd - b_rd), 240'(6));
    chk("pin_small_jobdone", 240'(cnt_jd - b_jd), 240'(1));
    tick();

    // big job with input gaps
    snap();
    run_load(1'b1, 40, 1'b0, 1'b0, 0);
    wait_start();
    respond(5);
    run_reads(1'b0);
    chk("pin_big_writes", 240'(cnt_we - b_we), 240'(12));
    chk("pin_big_lastaddr", 240'(wedone_addr), 240'(11));
    chk("pin_big_maxaddr", 240'(max_we_addr), 240'(11));
    chk("pin_big_reads", 240'(cnt_rd - b_rd), 240'(6));

    // host stall on word 2, mode toggling and spurious res_done during load
    full_job(1'b0, 20, 1'b1, 1'b1, 1'b1);
    chk("pin_stall_reads", 240'(cnt_rd - b_rd), 240'(6));
    chk("pin_toggle_writes", 240'(cnt_we - b_we), 240'(6));

    // watchdog expiry
    snap();
    run_load(1'b0, 0, 1'b0, 1'b0, 0);
    wait_start();
    g = 0;
    while (cnt_jd == b_jd && g < WD + 50) begin
      tick();
      g++;
    end
    if (g >= WD + 50) timeout_fail("watchdog_job_done");
    chk("pin_wd_err", 240'(wd_err), 240'(1));
    chk("pin_wd_latency", 240'(jd_cyc - start_cyc), 240'(WD));
    chk("pin_wd_no_reads", 240'(cnt_rd - b_rd), 240'(0));

    // next job clears the sticky flag
    full_job(1'b1, 10, 1'b0, 1'b0, 1'b0);
    chk("pin_wd_cleared", 240'(wd_err), 240'(0));

    // reset mid-load after beat 3
    snap();
    run_load(1'b1, 0, 1'b0, 1'b0, 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("pin_abort_in_ready", 240'(in_ready), 240'(1));
    chk("pin_abort_busy", 240'(busy), 240'(0));
    repeat (20) tick();
    chk("pin_abort_no_start", 240'(cnt_start - b_start), 240'(0));
    chk("pin_abort_writes", 240'(cnt_we - b_we), 240'(4));

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      full_job(1'($urandom_range(1)), $urandom_range(60), 1'($urandom_range(1)),
               1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, failures=%0d", failures);
    $fatal(1);
  end

endmodule
